// File: rtl/twf_conj_mul_fac8_pkg.sv
// Shared constants and twiddle lookup for the fac8 conjugate twiddle multiplier (IFFT path).
package twf_conj_mul_fac8_pkg;

  localparam int WIDTH      = 13;   // <5.6> signed sample
  localparam int TWF_WIDTH  = 10;   // <2.8> signed twiddle
  localparam int MUL_WIDTH  = 23;   // <7.14> product / sum
  localparam int DOUT_WIDTH = 15;   // <7.6> signed output
  localparam int DEPTH      = 8;
  localparam int NPATH      = 4;
  localparam int PHASE_LEN  = 4;

  localparam int PATH_ADD_1 = 0;
  localparam int PATH_ADD_2 = 1;
  localparam int PATH_SUB_1 = 2;
  localparam int PATH_SUB_2 = 3;

  localparam int TWF_256   = 256;
  localparam int TWF_181   = 181;
  localparam int RND       = 128;
  localparam int RND_SHIFT = 8;

  typedef logic signed [TWF_WIDTH-1:0] twf_word_t;

  typedef struct packed {
    twf_word_t w_r;
    twf_word_t w_q;
  } twf_t;

  // Twiddle W (not conjugated) for a given phase and path; the lane applies the conjugation.
  function automatic twf_t twf_lookup(input logic phase, input logic [1:0] path);
    twf_t t;
    t.w_r = twf_word_t'(TWF_256);
    t.w_q = twf_word_t'(0);
    case (path)
      2'(PATH_ADD_1): begin
        t.w_r = twf_word_t'(TWF_256);
        t.w_q = twf_word_t'(0);
      end
      2'(PATH_ADD_2): begin
        if (phase) begin
          t.w_r = twf_word_t'(TWF_181);
          t.w_q = twf_word_t'(-TWF_181);
        end else begin
          t.w_r = twf_word_t'(TWF_256);
          t.w_q = twf_word_t'(0);
        end
      end
      2'(PATH_SUB_1): begin
        t.w_r = twf_word_t'(TWF_256);
        t.w_q = twf_word_t'(0);
      end
      2'(PATH_SUB_2): begin
        if (phase) begin
          t.w_r = twf_word_t'(-TWF_181);
          t.w_q = twf_word_t'(-TWF_181);
        end else begin
          t.w_r = twf_word_t'(0);
          t.w_q = twf_word_t'(-TWF_256);
        end
      end
      default: begin
        t.w_r = twf_word_t'(TWF_256);
        t.w_q = twf_word_t'(0);
      end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/twf_conj_mul_fac8_if.sv
// Sample/result bus of the conjugate twiddle multiplier.
interface twf_conj_mul_fac8_if #(
  parameter int WIDTH      = 13,
  parameter int DOUT_WIDTH = 15,
  parameter int DEPTH      = 8,
  parameter int NPATH      = 4
);
  logic                                         frame_start;
  logic                                         din_valid;
  logic [NPATH-1:0][DEPTH-1:0][WIDTH-1:0]       din_R;
  logic [NPATH-1:0][DEPTH-1:0][WIDTH-1:0]       din_Q;
  logic                                         dout_valid;
  logic [NPATH-1:0][DEPTH-1:0][DOUT_WIDTH-1:0]  dout_R;
  logic [NPATH-1:0][DEPTH-1:0][DOUT_WIDTH-1:0]  dout_Q;
  logic                                         phase_out;
  logic                                         sat_flag;

  modport master (
    output frame_start, din_valid, din_R, din_Q,
    input  dout_valid, dout_R, dout_Q, phase_out, sat_flag
  );

  modport slave (
    input  frame_start, din_valid, din_R, din_Q,
    output dout_valid, dout_R, dout_Q, phase_out, sat_flag
  );
endinterface

// File: rtl/twf_conj_mul_fac8_lane.sv
// One lane: 2-stage x * conj(W) with round-half-up and output saturation.
module cmul_conj_lane
  import twf_conj_mul_fac8_pkg::*;
#(
  parameter int WIDTH      = 13,
  parameter int TWF_WIDTH  = 10,
  parameter int MUL_WIDTH  = 23,
  parameter int DOUT_WIDTH = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_s1,
  input  logic                         ld_s2,
  input  logic signed [WIDTH-1:0]      x_r,
  input  logic signed [WIDTH-1:0]      x_q,
  input  logic signed [TWF_WIDTH-1:0]  w_r,
  input  logic signed [TWF_WIDTH-1:0]  w_q,
  output logic signed [DOUT_WIDTH-1:0] y_r,
  output logic signed [DOUT_WIDTH-1:0] y_q,
  output logic                         sat
);

  localparam logic signed [MUL_WIDTH-1:0] OUT_MAX = MUL_WIDTH'((64'sd1 <<< (DOUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [MUL_WIDTH-1:0] OUT_MIN = MUL_WIDTH'(-(64'sd1 <<< (DOUT_WIDTH-1)));
  localparam logic signed [MUL_WIDTH-1:0] RND_W   = MUL_WIDTH'(RND);

  function automatic logic is_clip(input logic signed [MUL_WIDTH-1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  function automatic logic signed [DOUT_WIDTH-1:0] clip(input logic signed [MUL_WIDTH-1:0] v);
    logic signed [MUL_WIDTH-1:0] c;
    if (v > OUT_MAX) c = OUT_MAX;
    else if (v < OUT_MIN) c = OUT_MIN;
    else c = v;
    return DOUT_WIDTH'(c);
  endfunction

  logic signed [MUL_WIDTH-1:0] xr_ext, xq_ext, wr_ext, wq_ext;
  logic signed [MUL_WIDTH-1:0] p_rr_q, p_rr_d, p_qq_q, p_qq_d;
  logic signed [MUL_WIDTH-1:0] p_qr_q, p_qr_d, p_rq_q, p_rq_d;
  logic signed [MUL_WIDTH-1:0] sum_r, sum_q, rnd_r, rnd_q;
  logic signed [DOUT_WIDTH-1:0] y_r_q, y_r_d, y_q_q, y_q_d;

  // Stage 1: four partial products, loaded only on a valid input beat.
  always_comb begin
    xr_ext = MUL_WIDTH'(x_r);
    xq_ext = MUL_WIDTH'(x_q);
    wr_ext = MUL_WIDTH'(w_r);
    wq_ext = MUL_WIDTH'(w_q);
    p_rr_d = p_rr_q;
    p_qq_d = p_qq_q;
    p_qr_d = p_qr_q;
    p_rq_d = p_rq_q;
    if (ld_s1) begin
      p_rr_d = xr_ext * wr_ext;
      p_qq_d = xq_ext * wq_ext;
      p_qr_d = xq_ext * wr_ext;
      p_rq_d = xr_ext * wq_ext;
    end else begin
      p_rr_d = p_rr_q;
      p_qq_d = p_qq_q;
      p_qr_d = p_qr_q;
      p_rq_d = p_rq_q;
    end
  end

  // Stage 2: conjugate sums, round (ties toward +inf) and clip; holds on idle.
  always_comb begin
    sum_r = p_rr_q + p_qq_q;
    sum_q = p_qr_q - p_rq_q;
    rnd_r = (sum_r + RND_W) >>> RND_SHIFT;
    rnd_q = (sum_q + RND_W) >>> RND_SHIFT;
    sat   = is_clip(rnd_r) | is_clip(rnd_q);
    y_r_d = y_r_q;
    y_q_d = y_q_q;
    if (ld_s2) begin
      y_r_d = clip(rnd_r);
      y_q_d = clip(rnd_q);
    end else begin
      y_r_d = y_r_q;
      y_q_d = y_q_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_rr_q <= '0;
      p_qq_q <= '0;
      p_qr_q <= '0;
      p_rq_q <= '0;
      y_r_q  <= '0;
      y_q_q  <= '0;
    end else begin
      p_rr_q <= p_rr_d;
      p_qq_q <= p_qq_d;
      p_qr_q <= p_qr_d;
      p_rq_q <= p_rq_d;
      y_r_q  <= y_r_d;
      y_q_q  <= y_q_d;
    end
  end

  assign y_r = y_r_q;
  assign y_q = y_q_q;

endmodule

// File: rtl/twf_conj_mul_fac8.sv
// fac8 conjugate twiddle multiplier: beat/phase sequencer, valid pipeline, NPATH x DEPTH lanes.
module twf_conj_mul_fac8
  import twf_conj_mul_fac8_pkg::*;
#(
  parameter int WIDTH      = twf_conj_mul_fac8_pkg::WIDTH,
  parameter int TWF_WIDTH  = twf_conj_mul_fac8_pkg::TWF_WIDTH,
  parameter int MUL_WIDTH  = twf_conj_mul_fac8_pkg::MUL_WIDTH,
  parameter int DOUT_WIDTH = twf_conj_mul_fac8_pkg::DOUT_WIDTH,
  parameter int DEPTH      = twf_conj_mul_fac8_pkg::DEPTH,
  parameter int NPATH      = twf_conj_mul_fac8_pkg::NPATH,
  parameter int PHASE_LEN  = twf_conj_mul_fac8_pkg::PHASE_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  twf_conj_mul_fac8_if.slave    bus
);

  localparam int BEAT_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PHASE_LEN - 1);

  logic [BEAT_W-1:0] beat_q, beat_d, start_beat;
  logic phase_q, phase_d, cur_phase;
  logic v1_q, v1_d, dv_q, dv_d;
  logic ph1_q, ph1_d, phase_out_q, phase_out_d;
  logic sat_flag_q, sat_flag_d;
  logic [NPATH*DEPTH-1:0] lane_sat;
  logic [NPATH-1:0][DEPTH-1:0][DOUT_WIDTH-1:0] dout_r, dout_q;

  // Sequencer: phase for the current beat and next beat/phase (frame_start restarts at beat 0 phase 0).
  always_comb begin
    cur_phase  = phase_q;
    start_beat = beat_q;
    beat_d     = beat_q;
    phase_d    = phase_q;
    if (bus.din_valid) begin
      if (bus.frame_start) begin
        cur_phase  = 1'b0;
        start_beat = '0;
      end else begin
        cur_phase  = phase_q;
        start_beat = beat_q;
      end
      if (start_beat == BEAT_LAST) begin
        beat_d  = '0;
        phase_d = ~cur_phase;
      end else begin
        beat_d  = start_beat + BEAT_W'(1);
        phase_d = cur_phase;
      end
    end else begin
      beat_d  = beat_q;
      phase_d = phase_q;
    end
  end

  // Valid/phase pipeline alongside the lane stages, plus sticky saturation flag.
  always_comb begin
    v1_d        = bus.din_valid;
    dv_d        = v1_q;
    ph1_d       = bus.din_valid ? cur_phase : ph1_q;
    phase_out_d = v1_q ? ph1_q : phase_out_q;
    sat_flag_d  = sat_flag_q | (v1_q & (|lane_sat));
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q      <= '0;
      phase_q     <= 1'b0;
      v1_q        <= 1'b0;
      dv_q        <= 1'b0;
      ph1_q       <= 1'b0;
      phase_out_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      phase_q     <= phase_d;
      v1_q        <= v1_d;
      dv_q        <= dv_d;
      ph1_q       <= ph1_d;
      phase_out_q <= phase_out_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  for (genvar p = 0; p < NPATH; p++) begin : g_path
    twf_t tw;
    assign tw = twf_lookup(cur_phase, 2'(p));
    for (genvar l = 0; l < DEPTH; l++) begin : g_lane
      cmul_conj_lane #(
        .WIDTH      (WIDTH),
        .TWF_WIDTH  (TWF_WIDTH),
        .MUL_WIDTH  (MUL_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .ld_s1 (bus.din_valid),
        .ld_s2 (v1_q),
        .x_r   (bus.din_R[p][l]),
        .x_q   (bus.din_Q[p][l]),
        .w_r   (TWF_WIDTH'(tw.w_r)),
        .w_q   (TWF_WIDTH'(tw.w_q)),
        .y_r   (dout_r[p][l]),
        .y_q   (dout_q[p][l]),
        .sat   (lane_sat[p*DEPTH+l])
      );
    end
  end

  assign bus.dout_R     = dout_r;
  assign bus.dout_Q     = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.phase_out  = phase_out_q;
  assign bus.sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_twf_conj_mul_fac8.sv
// Scoreboard bench for twf_conj_mul_fac8: default DOUT_WIDTH and a 12-bit output instance driven identically.
module tb_twf_conj_mul_fac8;
  localparam int W = 13, DW = 15, DW12 = 12, D = 8, NP = 4, PL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twf_conj_mul_fac8_if #(.WIDTH(W), .DOUT_WIDTH(DW),   .DEPTH(D), .NPATH(NP)) bus ();
  twf_conj_mul_fac8_if #(.WIDTH(W), .DOUT_WIDTH(DW12), .DEPTH(D), .NPATH(NP)) bus12 ();

  twf_conj_mul_fac8 #(.DOUT_WIDTH(DW))   dut   (.clk(clk), .rst(rst), .bus(bus));
  twf_conj_mul_fac8 #(.DOUT_WIDTH(DW12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  // independent twiddle table [phase][path]
  int TW_R [2][4] = '{'{256, 256, 256, 0},    '{256, 181, 256, -181}};
  int TW_Q [2][4] = '{'{0,   0,   0,   -256}, '{0,   -181, 0,  -181}};

  typedef struct {
    bit           ph;
    logic [479:0] r15, q15, r12, q12;
    bit           sat15, sat12;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int xr [NP][D];
  int xq [NP][D];
  bit hist [2];
  int mbeat, mphase;
  logic [479:0] last_r15, last_q15, last_r12, last_q12;
  bit last_ph, sat15_m, sat12_m;

  task automatic check_val(input string tag, input logic [479:0] act, input logic [479:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int rdiv(input int s);
    int t;
    t = s + 128;
    return (t >= 0) ? t / 256 : -((-t + 255) / 256);
  endfunction

  function automatic int clipi(input int v, input int dw, inout bit s);
    int hi, lo;
    hi = (1 << (dw - 1)) - 1;
    lo = -(1 << (dw - 1));
    if (v > hi) begin s = 1'b1; return hi; end
    if (v < lo) begin s = 1'b1; return lo; end
    return v;
  endfunction

  function automatic void lane_model(input int a, input int b, input int p, input int ph, input int dw,
                                     output int r, output int q, inout bit s);
    int sr, sq;
    sr = a * TW_R[ph][p] + b * TW_Q[ph][p];
    sq = b * TW_R[ph][p] - a * TW_Q[ph][p];
    r  = clipi(rdiv(sr), dw, s);
    q  = clipi(rdiv(sq), dw, s);
  endfunction

  task automatic clear_x();
    for (int p = 0; p < NP; p++)
      for (int l = 0; l < D; l++) begin
        xr[p][l] = 0;
        xq[p][l] = 0;
      end
  endtask

  task automatic rand_x(input int lim);
    for (int p = 0; p < NP; p++)
      for (int l = 0; l < D; l++) begin
        xr[p][l] = int'($urandom_range(2 * lim, 0)) - lim;
        xq[p][l] = int'($urandom_range(2 * lim, 0)) - lim;
      end
  endtask

  task automatic check_outputs();
    exp_t e;
    bit ev;
    ev = hist[1];
    check_val("dout_valid",   480'(bus.dout_valid),   480'(ev));
    check_val("dout_valid12", 480'(bus12.dout_valid), 480'(ev));
    if (ev) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 480'(sb.size()), 480'(1));
      end else begin
        e = sb.pop_front();
        last_r15 = e.r15; last_q15 = e.q15;
        last_r12 = e.r12; last_q12 = e.q12;
        last_ph  = e.ph;
        sat15_m  = sat15_m | e.sat15;
        sat12_m  = sat12_m | e.sat12;
      end
    end
    check_val("dout_R",     480'(bus.dout_R),     last_r15);
    check_val("dout_Q",     480'(bus.dout_Q),     last_q15);
    check_val("dout_R12",   480'(bus12.dout_R),   last_r12);
    check_val("dout_Q12",   480'(bus12.dout_Q),   last_q12);
    check_val("phase_out",  480'(bus.phase_out),  480'(last_ph));
    check_val("phase_out12",480'(bus12.phase_out),480'(last_ph));
    check_val("sat_flag",   480'(bus.sat_flag),   480'(sat15_m));
    check_val("sat_flag12", 480'(bus12.sat_flag), 480'(sat12_m));
  endtask

  task automatic drive(input bit v, input bit fs);
    exp_t e;
    int b, ph, r, q;
    for (int p = 0; p < NP; p++)
      for (int l = 0; l < D; l++) begin
        bus.din_R[p][l]   = W'(xr[p][l]);
        bus.din_Q[p][l]   = W'(xq[p][l]);
        bus12.din_R[p][l] = W'(xr[p][l]);
        bus12.din_Q[p][l] = W'(xq[p][l]);
      end
    bus.din_valid   = v;  bus.frame_start   = fs;
    bus12.din_valid = v;  bus12.frame_start = fs;
    if (v) begin
      if (fs) begin ph = 0; b = 0; end
      else begin ph = mphase; b = mbeat; end
      e.ph = ph[0];
      e.sat15 = 1'b0; e.sat12 = 1'b0;
      e.r15 = '0; e.q15 = '0; e.r12 = '0; e.q12 = '0;
      for (int p = 0; p < NP; p++)
        for (int l = 0; l < D; l++) begin
          lane_model(xr[p][l], xq[p][l], p, ph, DW, r, q, e.sat15);
          e.r15[(p*D+l)*DW +: DW] = DW'(r);
          e.q15[(p*D+l)*DW +: DW] = DW'(q);
          lane_model(xr[p][l], xq[p][l], p, ph, DW12, r, q, e.sat12);
          e.r12[(p*D+l)*DW12 +: DW12] = DW12'(r);
          e.q12[(p*D+l)*DW12 +: DW12] = DW12'(q);
        end
      sb.push_back(e);
      if (b == PL - 1) begin mbeat = 0; mphase = 1 - ph; end
      else begin mbeat = b + 1; mphase = ph; end
    end
    hist[1] = hist[0];
    hist[0] = v;
  endtask

  task automatic cycle(input bit v, input bit fs);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    drive(v, fs);
  endtask

  task automatic clear_model();
    sb.delete();
    hist[0] = 1'b0; hist[1] = 1'b0;
    last_r15 = '0; last_q15 = '0; last_r12 = '0; last_q12 = '0;
    last_ph = 1'b0; sat15_m = 1'b0; sat12_m = 1'b0;
    mbeat = 0; mphase = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    clear_x();
    drive(1'b0, 1'b0);
    clear_model();
  endtask

  initial begin
    int pat [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
    rst = 1'b1;
    clear_x();
    drive(1'b0, 1'b0);
    clear_model();
    do_reset();
    cycle(1'b0, 1'b0);

    // single beat, p3 lane0 x=(100,50) in phase 0
    clear_x();
    xr[3][0] = 100; xq[3][0] = 50;
    cycle(1'b1, 1'b1);
    clear_x();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("p3_l0_R", 480'(bus.dout_R[3][0]), 480'(15'h7FCE));
    check_val("p3_l0_Q", 480'(bus.dout_Q[3][0]), 480'(15'd100));

    // three more beats to wrap into phase 1, then p1/p0 x=(256,0)
    for (int i = 0; i < 3; i++) begin rand_x(1000); cycle(1'b1, 1'b0); end
    clear_x();
    xr[1][0] = 256; xr[0][0] = 256;
    cycle(1'b1, 1'b0);
    clear_x();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("p1_ph1_R", 480'(bus.dout_R[1][0]), 480'(15'd181));
    check_val("p1_ph1_Q", 480'(bus.dout_Q[1][0]), 480'(15'd181));
    check_val("p0_ph1_R", 480'(bus.dout_R[0][0]), 480'(15'd256));
    check_val("ph1_out",  480'(bus.phase_out),     480'(1'b1));

    // rounding at phase 0 on p0
    clear_x(); xr[0][0] = -1;                       cycle(1'b1, 1'b1);
    clear_x(); xr[0][0] = 1;                        cycle(1'b1, 1'b0);
    clear_x(); xr[0][0] = -2048; xq[0][0] = 2047;  cycle(1'b1, 1'b0);
    clear_x();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("rnd_big_R", 480'(bus.dout_R[0][0]), 480'(15'h7800));
    check_val("rnd_big_Q", 480'(bus.dout_Q[0][0]), 480'(15'd2047));

    // back-to-back random beats
    for (int i = 0; i < 10; i++) begin rand_x(1000); cycle(1'b1, 1'b0); end

    // gapped stream starting a fresh frame
    for (int i = 0; i < 9; i++) begin
      rand_x(1000);
      cycle(pat[i] != 0, i == 0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

    // frame_start at beat 2 of phase 1
    for (int i = 0; i < 16 && !(mbeat == 2 && mphase == 1); i++) begin rand_x(1000); cycle(1'b1, 1'b0); end
    rand_x(1000); cycle(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin rand_x(1000); cycle(1'b1, 1'b0); end
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("sat12_clear", 480'(bus12.sat_flag), 480'(1'b0));

    // saturation on the 12-bit instance: p1 phase 1 x=(2047,2047)
    clear_x(); cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    xr[1][0] = 2047; xq[1][0] = 2047;
    cycle(1'b1, 1'b0);
    clear_x();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("sat12_set", 480'(bus12.sat_flag), 480'(1'b1));
    check_val("sat15_off", 480'(bus.sat_flag),   480'(1'b0));
    for (int i = 0; i < 4; i++) begin rand_x(1000); cycle(1'b1, 1'b0); end

    // reset mid-stream with beats in flight, then restart without frame_start
    do_reset();
    cycle(1'b0, 1'b0);
    check_val("rst_sat12", 480'(bus12.sat_flag), 480'(1'b0));
    for (int i = 0; i < 6; i++) begin rand_x(1000); cycle(1'b1, 1'b0); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    check_val("sb_drained", 480'(sb.size()), 480'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
